// File: rtl/cpu_clock_controller.sv
// rtl/cpu_clock_controller.sv - run/stop/single-step CPU clock-enable controller (optional ce_count via CPU_CLOCK_CTRL_CE_COUNT_EN)
module cpu_clock_controller #(
    parameter int unsigned RATIO0   = 2,
    parameter int unsigned RATIO1   = 1000,
    parameter int unsigned RATIO2   = 1000000,
    parameter int unsigned RATIO3   = 50000000,
    parameter int unsigned DEBOUNCE = 500000
) (
    input  logic        clk_quick,
    input  logic        rst_n,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic [1:0]  ratio_sel,
    input  logic        halt,
    output logic        cpu_ce,
    output logic        running,
    output logic [31:0] ce_count
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    localparam logic [31:0] R0 = 32'(RATIO0);
    localparam logic [31:0] R1 = 32'(RATIO1);
    localparam logic [31:0] R2 = 32'(RATIO2);
    localparam logic [31:0] R3 = 32'(RATIO3);
    // DEBOUNCE of 0 or 1 both mean "accept on the first differing cycle"
    localparam logic [31:0] DB_LAST = (DEBOUNCE <= 1) ? 32'd0 : 32'(DEBOUNCE - 1);

    logic        run_meta_q, run_sync_q;
    logic        step_meta_q, step_sync_q;
    logic [31:0] db_cnt_q, db_cnt_d;
    logic        db_level_q, db_level_d;
    logic        step_evt;
    logic [31:0] ratio_q, ratio_d;
    logic [31:0] ratio_sel_val;
    logic [31:0] ratio_eff;
    logic        period_end;
    logic [31:0] div_cnt_q, div_cnt_d;
    logic        armed_q, armed_d;
    logic        cpu_ce_q, cpu_ce_d;
    logic        running_q;
    state_t      state_q, state_d;

    // two-flop synchronizers for the asynchronous operator inputs
    always_ff @(posedge clk_quick or negedge rst_n) begin
        if (!rst_n) begin
            run_meta_q  <= 1'b0;
            run_sync_q  <= 1'b0;
            step_meta_q <= 1'b0;
            step_sync_q <= 1'b0;
        end else begin
            run_meta_q  <= run_sw;
            run_sync_q  <= run_meta_q;
            step_meta_q <= step_btn;
            step_sync_q <= step_meta_q;
        end
    end

    // debounce: count consecutive differing cycles, accept the new level at DEBOUNCE
    always_comb begin
        db_cnt_d   = db_cnt_q;
        db_level_d = db_level_q;
        step_evt   = 1'b0;
        if (step_sync_q == db_level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q >= DB_LAST) begin
            db_level_d = step_sync_q;
            db_cnt_d   = '0;
            step_evt   = step_sync_q;
        end else begin
            db_cnt_d = db_cnt_q + 32'd1;
        end
    end

    // decode the ratio select into a divide value for the latch
    always_comb begin
        ratio_sel_val = R0;
        case (ratio_sel)
            2'd0:    ratio_sel_val = R0;
            2'd1:    ratio_sel_val = R1;
            2'd2:    ratio_sel_val = R2;
            default: ratio_sel_val = R3;
        endcase
    end

    // a latched ratio of zero behaves like one (pulse every cycle)
    assign ratio_eff  = (ratio_q == 32'd0) ? 32'd1 : ratio_q;
    assign period_end = (div_cnt_q == (ratio_eff - 32'd1));

    // FSM next state, divider, ratio latch, arming and the cpu_ce request
    always_comb begin
        state_d   = state_q;
        div_cnt_d = '0;
        ratio_d   = ratio_q;
        armed_d   = armed_q;
        cpu_ce_d  = 1'b0;

        // a halt disarms; once the switch is seen low the operator may run again
        if (halt && (state_q != ST_STEP)) begin
            armed_d = 1'b0;
        end else if (!run_sync_q) begin
            armed_d = 1'b1;
        end

        case (state_q)
            ST_STOP: begin
                ratio_d = ratio_sel_val;
                if (run_sync_q && armed_q) begin
                    state_d = ST_RUN;
                end else if (step_evt) begin
                    state_d  = ST_STEP;
                    cpu_ce_d = 1'b1;
                end
            end
            ST_STEP: begin
                state_d = ST_STOP;
            end
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_STOP;
                end else if (!run_sync_q) begin
                    state_d = ST_STOP;
                end else if (period_end) begin
                    cpu_ce_d = 1'b1;
                    ratio_d  = ratio_sel_val;
                end else begin
                    div_cnt_d = div_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_STOP;
            end
        endcase
    end

    // state and registered outputs
    always_ff @(posedge clk_quick or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_STOP;
            div_cnt_q  <= '0;
            ratio_q    <= R0;
            armed_q    <= 1'b1;
            cpu_ce_q   <= 1'b0;
            running_q  <= 1'b0;
            db_cnt_q   <= '0;
            db_level_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            ratio_q    <= ratio_d;
            armed_q    <= armed_d;
            cpu_ce_q   <= cpu_ce_d;
            running_q  <= (state_d == ST_RUN);
            db_cnt_q   <= db_cnt_d;
            db_level_q <= db_level_d;
        end
    end

    assign cpu_ce  = cpu_ce_q;
    assign running = running_q;

`ifdef CPU_CLOCK_CTRL_CE_COUNT_EN
    logic [31:0] ce_count_q;

    // count every cycle the CPU was enabled; wraps naturally at 2^32
    always_ff @(posedge clk_quick or negedge rst_n) begin
        if (!rst_n) begin
            ce_count_q <= '0;
        end else if (cpu_ce_q) begin
            ce_count_q <= ce_count_q + 32'd1;
        end
    end

    assign ce_count = ce_count_q;
`else
    assign ce_count = 32'd0;
`endif

endmodule

// File: tb/tb_cpu_clock_controller.sv
// tb/tb_cpu_clock_controller.sv - directed self-checking bench for cpu_clock_controller
module tb_cpu_clock_controller;

`ifdef CPU_CLOCK_CTRL_CE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk_quick;
    logic        rst_n;
    logic        run_sw;
    logic        step_btn;
    logic [1:0]  ratio_sel;
    logic        halt;
    logic        cpu_ce;
    logic        running;
    logic [31:0] ce_count;

    int checks;
    int failures;
    int pulses;

    cpu_clock_controller #(
        .RATIO0   (2),
        .RATIO1   (5),
        .RATIO2   (1),
        .RATIO3   (0),
        .DEBOUNCE (4)
    ) dut (
        .clk_quick (clk_quick),
        .rst_n     (rst_n),
        .run_sw    (run_sw),
        .step_btn  (step_btn),
        .ratio_sel (ratio_sel),
        .halt      (halt),
        .cpu_ce    (cpu_ce),
        .running   (running),
        .ce_count  (ce_count)
    );

    initial begin
        clk_quick = 1'b0;
        forever #5 clk_quick = ~clk_quick;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_quick);
            #1;
        end
    endtask

    task automatic count_pulses(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(posedge clk_quick);
            #1;
            if (cpu_ce === 1'b1) cnt++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        run_sw    = 1'b0;
        step_btn  = 1'b0;
        ratio_sel = 2'd1;
        halt      = 1'b0;

        // reset state
        tick(3);
        check("rst_cpu_ce", 32'(cpu_ce), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_ce_count", ce_count, 32'd0);
        rst_n = 1'b1;
        count_pulses(10, pulses);
        check("idle_pulses", 32'(pulses), 32'd0);
        check("idle_running", 32'(running), 32'd0);

        // run at ratio 5: running rises 3 cycles after the switch
        run_sw = 1'b1;
        tick(1);
        check("run_lat1", 32'(running), 32'd0);
        tick(1);
        check("run_lat2", 32'(running), 32'd0);
        tick(1);
        check("run_lat3", 32'(running), 32'd1);

        // pulses every 5 cycles; switch to ratio 2 two cycles into a period
        for (int i = 1; i <= 26; i++) begin
            tick(1);
            check($sformatf("div_ce_%0d", i), 32'(cpu_ce),
                  32'((i <= 20) ? (i % 5 == 0) : (i % 2 == 0)));
            if (i == 17) ratio_sel = 2'd0;
        end
        tick(1);
        check("div_ce_count", ce_count, CNT_EN ? 32'd7 : 32'd0);
        tick(1);
        check("pre_rst_ce", 32'(cpu_ce), 32'd1);

        // asynchronous reset in the middle of a pulse
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_ce", 32'(cpu_ce), 32'd0);
        check("async_rst_running", 32'(running), 32'd0);
        check("async_rst_count", ce_count, 32'd0);
        tick(2);
        run_sw = 1'b0;
        rst_n  = 1'b1;
        count_pulses(8, pulses);
        check("post_rst_pulses", 32'(pulses), 32'd0);
        check("post_rst_running", 32'(running), 32'd0);

        // bouncy step press yields one pulse
        step_btn = 1'b1;
        count_pulses(2, pulses);
        check("bounce_a", 32'(pulses), 32'd0);
        step_btn = 1'b0;
        count_pulses(2, pulses);
        check("bounce_b", 32'(pulses), 32'd0);
        step_btn = 1'b1;
        count_pulses(10, pulses);
        check("step1_pulses", 32'(pulses), 32'd1);
        check("step1_running", 32'(running), 32'd0);

        // bouncy release yields nothing
        step_btn = 1'b0;
        count_pulses(2, pulses);
        step_btn = 1'b1;
        count_pulses(2, pulses);
        check("release_bounce", 32'(pulses), 32'd0);
        step_btn = 1'b0;
        count_pulses(10, pulses);
        check("release_pulses", 32'(pulses), 32'd0);

        // second clean press
        step_btn = 1'b1;
        count_pulses(10, pulses);
        check("step2_pulses", 32'(pulses), 32'd1);
        step_btn = 1'b0;
        count_pulses(8, pulses);
        check("step2_release", 32'(pulses), 32'd0);
        check("step_ce_count", ce_count, CNT_EN ? 32'd2 : 32'd0);

        // halt at count==1 with ratio 2 suppresses the pulse and stops
        ratio_sel = 2'd0;
        run_sw    = 1'b1;
        tick(3);
        check("halt_run_up", 32'(running), 32'd1);
        tick(1);
        check("halt_pre_ce", 32'(cpu_ce), 32'd0);
        halt = 1'b1;
        tick(1);
        check("halt_ce", 32'(cpu_ce), 32'd0);
        check("halt_running", 32'(running), 32'd0);
        halt = 1'b0;
        count_pulses(8, pulses);
        check("halt_hold_pulses", 32'(pulses), 32'd0);
        check("halt_hold_running", 32'(running), 32'd0);

        // re-arm: drop and raise the switch
        run_sw = 1'b0;
        tick(4);
        run_sw = 1'b1;
        tick(3);
        check("rearm_running", 32'(running), 32'd1);
        tick(1);
        check("rearm_ce0", 32'(cpu_ce), 32'd0);
        tick(1);
        check("rearm_ce1", 32'(cpu_ce), 32'd1);
        check("rearm_count", ce_count, CNT_EN ? 32'd2 : 32'd0);

        run_sw = 1'b0;
        tick(3);
        check("stop_running", 32'(running), 32'd0);
        tick(3);

        // step event coincides with run_sw_sync rising: run wins, no step pulse
        step_btn = 1'b1;
        tick(3);
        run_sw = 1'b1;
        tick(2);
        check("prio_pre", 32'(running), 32'd0);
        tick(1);
        check("prio_running", 32'(running), 32'd1);
        check("prio_ce", 32'(cpu_ce), 32'd0);
        tick(1);
        check("prio_ce_a", 32'(cpu_ce), 32'd0);
        tick(1);
        check("prio_ce_b", 32'(cpu_ce), 32'd1);

        // ratio 1 and latched ratio 0 both pulse every cycle
        run_sw = 1'b0;
        tick(4);
        check("r1_stop", 32'(running), 32'd0);
        ratio_sel = 2'd2;
        tick(1);
        run_sw = 1'b1;
        tick(3);
        check("r1_running", 32'(running), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check($sformatf("r1_ce_%0d", i), 32'(cpu_ce), 32'd1);
        end
        ratio_sel = 2'd3;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check($sformatf("r0_ce_%0d", i), 32'(cpu_ce), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
